// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the DAC sample sequencer.
// The sequencer FSM encoding and the prime threshold live here.
package dac_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } seq_state_e;

    localparam int unsigned PRIME_MIN_FILL = 2;
    localparam int unsigned UF_CNT_W       = 16;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Small synchronous FIFO between the sample generator and the sequencer.
// Show-ahead read: dout always presents the head entry.
module dac_sample_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_W-1:0]         din,
    output logic [DATA_W-1:0]         dout,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {(PTR_W+1){1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array; contents are don't-care once the pointers reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Read/write pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Occupancy; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {(PTR_W+1){1'b0}};
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/dac_sample_sequencer.sv
// Paces FIFO-buffered samples into the DAC at a programmable period.
// Optional DAC_SEQ_UFCNT_EN adds a saturating underflow event counter (uf_count).
module dac_sample_sequencer
    import dac_seq_pkg::*;
#(
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        DIV_W      = 16,
    parameter int unsigned        FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0]  IDLE_CODE  = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DIV_W-1:0]      div,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_W-1:0]     dac_data,
    output logic                  dac_load,
    output logic                  busy,
    output logic                  underflow
`ifdef DAC_SEQ_UFCNT_EN
    ,
    output logic [UF_CNT_W-1:0]   uf_count
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] MIN_FILL = CNT_W'(PRIME_MIN_FILL);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

    seq_state_e          state_r;
    seq_state_e          state_nx_s;
    logic [DIV_W-1:0]    cnt_r;
    logic [DIV_W-1:0]    div_q_r;
    logic [DIV_W-1:0]    div_eff_s;
    logic [DATA_W-1:0]   dac_data_r;
    logic                dac_load_r;
    logic                busy_r;
    logic                underflow_r;

    logic [DATA_W-1:0]   fifo_dout_s;
    logic [CNT_W-1:0]    fifo_count_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                push_s;
    logic                fill_ok_s;
    logic                counting_s;
    logic                tick_s;

    logic                pop_s;
    logic                idle_load_s;
    logic                uf_hit_s;
    logic                clr_uf_s;
    logic                latch_div_s;

    assign push_s     = s_valid && !fifo_full_s;
    assign s_ready    = !fifo_full_s;
    assign fill_ok_s  = (fifo_count_s >= MIN_FILL) || fifo_full_s;
    assign div_eff_s  = (div == DIV_ZERO) ? DIV_ONE : div;
    assign counting_s = (state_r == ST_RUN) || (state_r == ST_STOP);
    assign tick_s     = counting_s && (cnt_r == DIV_ZERO);

    dac_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   (s_data),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; STOP ignores enable until the closing tick.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nx_s = ST_PRIME;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PRIME: begin
                if (!enable) begin
                    state_nx_s = ST_IDLE;
                end else if (fill_ok_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_PRIME;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_nx_s = ST_STOP;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_STOP;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM action decode; a RUN tick with an empty FIFO only flags underflow.
    always_comb begin
        pop_s       = 1'b0;
        idle_load_s = 1'b0;
        uf_hit_s    = 1'b0;
        clr_uf_s    = 1'b0;
        latch_div_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clr_uf_s = enable;
            end
            ST_PRIME: begin
                latch_div_s = enable && fill_ok_s;
            end
            ST_RUN: begin
                if (tick_s) begin
                    pop_s    = !fifo_empty_s;
                    uf_hit_s = fifo_empty_s;
                end else begin
                    pop_s    = 1'b0;
                    uf_hit_s = 1'b0;
                end
            end
            ST_STOP: begin
                idle_load_s = tick_s;
            end
            default: begin
                pop_s       = 1'b0;
                idle_load_s = 1'b0;
            end
        endcase
    end

    // Sample-period divider: period latched at RUN entry, reload-only countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= DIV_ZERO;
            div_q_r <= DIV_ONE;
        end else if (latch_div_s) begin
            cnt_r   <= div_eff_s - DIV_ONE;
            div_q_r <= div_eff_s;
        end else if (counting_s) begin
            cnt_r <= tick_s ? (div_q_r - DIV_ONE) : (cnt_r - DIV_ONE);
        end
    end

    // DAC output registers; dac_load is aligned with each dac_data update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_data_r <= IDLE_CODE;
            dac_load_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            if (pop_s) begin
                dac_data_r <= fifo_dout_s;
            end else if (idle_load_s) begin
                dac_data_r <= IDLE_CODE;
            end
            dac_load_r <= pop_s || idle_load_s;
            busy_r     <= (state_nx_s != ST_IDLE);
        end
    end

    // Sticky underflow flag, cleared when a new run is armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_r <= 1'b0;
        end else if (clr_uf_s) begin
            underflow_r <= 1'b0;
        end else if (uf_hit_s) begin
            underflow_r <= 1'b1;
        end
    end

    assign dac_data  = dac_data_r;
    assign dac_load  = dac_load_r;
    assign busy      = busy_r;
    assign underflow = underflow_r;

`ifdef DAC_SEQ_UFCNT_EN
    logic [UF_CNT_W-1:0] uf_count_r;

    // Saturating count of empty-at-tick events, cleared when a run is armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uf_count_r <= {UF_CNT_W{1'b0}};
        end else if (clr_uf_s) begin
            uf_count_r <= {UF_CNT_W{1'b0}};
        end else if (uf_hit_s) begin
            uf_count_r <= sat_inc16(uf_count_r);
        end
    end

    assign uf_count = uf_count_r;
`endif

endmodule
